// File: rtl/inst_mem_loader.sv
// Runtime program loader: unpacks a framed byte stream into 16-bit words for instruction memory
// and holds the core in reset until a frame loads cleanly. Optional trailing XOR byte: LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic              clear_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = DONE;
`endif

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t      state, state_n;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [7:0]  hi_q;
  logic        acc;
  logic [15:0] len_full;
  logic        last_word;

  assign acc       = byte_valid_i & byte_ready_o;
  assign len_full  = {len_q[15:8], byte_i};
  assign last_word = (cnt_q == len_q - 16'd1);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       chk_ok;
  assign chk_ok = (chk_q == byte_i);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (acc && byte_i == SYNC_BYTE) state_n = LEN_HI;
      LEN_HI:  if (acc) state_n = LEN_LO;
      LEN_LO:
        if (acc) begin
          if ({1'b0, len_full} > DEPTH) state_n = ERR;
          else if (len_full == 16'd0)   state_n = END_ST;
          else                          state_n = DATA_HI;
        end
      DATA_HI: if (acc) state_n = DATA_LO;
      DATA_LO: if (acc) state_n = last_word ? END_ST : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      CHK:     if (acc) state_n = chk_ok ? DONE : ERR;
`else
      CHK:     state_n = IDLE;
`endif
      DONE:    state_n = IDLE;
      ERR:     if (clear_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Ready and error are derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      core_rst_o   <= !BOOT_HOLD;
      len_q        <= '0;
      cnt_q        <= '0;
      hi_q         <= '0;
    end else begin
      byte_ready_o <= !(state_n == DONE || state_n == ERR);
      error_o      <= (state_n == ERR);
      mem_we_o     <= 1'b0;
      unique case (state)
        IDLE:
          if (acc && byte_i == SYNC_BYTE) begin
            done_o     <= 1'b0;
            core_rst_o <= 1'b0;
            cnt_q      <= '0;
          end
        LEN_HI:  if (acc) len_q[15:8] <= byte_i;
        LEN_LO:  if (acc) len_q[7:0]  <= byte_i;
        DATA_HI: if (acc) hi_q        <= byte_i;
        DATA_LO:
          if (acc) begin
            mem_we_o    <= 1'b1;
            mem_wdata_o <= {hi_q, byte_i};
            mem_addr_o  <= cnt_q[ADDR_W-1:0];
            cnt_q       <= cnt_q + 16'd1;
          end
        DONE: begin
          done_o     <= 1'b1;
          core_rst_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over everything after the sync byte up to the check byte.
  always_ff @(posedge clk) begin
    if (!rst) chk_q <= '0;
    else if (acc) begin
      if (state == IDLE && byte_i == SYNC_BYTE) chk_q <= '0;
      else if (state == LEN_HI || state == LEN_LO || state == DATA_HI || state == DATA_LO)
        chk_q <= chk_q ^ byte_i;
    end
  end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized frame stimulus for inst_mem_loader, checked against a frame-level expectation model.
module tb_inst_mem_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic          clear_i = 1'b0;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [15:0]   mem_wdata_o;
  logic          core_rst_o, done_o, error_o;

  inst_mem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .clear_i(clear_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .core_rst_o(core_rst_o),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected write: which cycle it must appear in, where, and what.
  typedef struct {int due; logic [AW-1:0] addr; logic [15:0] data;} wr_t;
  wr_t         expq[$];
  wr_t         w;
  logic [15:0] obs_mem [DEPTH];
  int          sync_cyc = -10;
  bit          mon_en = 1'b0;
  bit          we_prev = 1'b0, done_prev = 1'b0, core_prev = 1'b0;

  always @(negedge clk) if (mon_en) begin
    if (expq.size() > 0 && expq[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL missed_write: no mem_we_o at cycle %0d, required addr %0h data %0h", expq[0].due, expq[0].addr, expq[0].data);
      void'(expq.pop_front());
    end
    if (mem_we_o) begin
      chk("we_back_to_back", we_prev, 0);
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: mem_we_o=1 addr %0h data %0h, required no write", mem_addr_o, mem_wdata_o);
      end else begin
        w = expq.pop_front();
        chk("write_cycle", cyc, w.due);
        chk("write_addr", mem_addr_o, w.addr);
        chk("write_data", mem_wdata_o, w.data);
      end
      obs_mem[mem_addr_o] = mem_wdata_o;
    end
    if (done_o && !done_prev) chk("core_rst_rises_with_done", {core_rst_o, core_prev}, 2'b10);
    if (error_o) chk("err_holds_core_and_stalls", {core_rst_o, byte_ready_o}, 2'b00);
    if (cyc == sync_cyc + 1) chk("sync_reasserts_core_rst", {core_rst_o, done_o}, 2'b00);
    we_prev   = mem_we_o;
    done_prev = done_o;
    core_prev = core_rst_o;
  end

  bit          stall = 1'b0;
  logic [15:0] words[$];

  task automatic drive_idle();
    @(negedge clk);
    byte_valid_i = 1'b0;
    byte_i = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, output int hs);
    hs = -1;
    for (int t = 0; t < 60 && hs < 0; t++) begin
      @(negedge clk);
      if (stall && (cyc % 3) != 0) begin
        byte_valid_i = 1'b0;
        byte_i = 8'($urandom);
      end else begin
        byte_valid_i = 1'b1;
        byte_i = b;
        if (byte_ready_o) hs = cyc;
      end
    end
    if (hs < 0) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: byte %0h saw byte_ready_o=0 for 60 cycles, required 1", b);
    end
  endtask

  function automatic logic [7:0] xor_of(input int len);
    logic [7:0] x;
    x = 8'(len >> 8) ^ 8'(len);
    foreach (words[i]) x = x ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction

  function automatic void rand_words(input int n);
    words = {};
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endfunction

  // Sends one frame (garbage prefix, header, words, optional check byte) and checks the outcome.
  task automatic run_frame(input int len, input int ngarb, input bit bad_chk);
    int hs;
    logic [7:0] g;
    bit ok;
    ok = (len <= DEPTH) && !(CHK_EN && bad_chk);
    for (int i = 0; i < ngarb; i++) begin
      do g = 8'($urandom); while (g == 8'hA5);
      send_byte(g, hs);
    end
    send_byte(8'hA5, hs);
    sync_cyc = hs;
    send_byte(8'(len >> 8), hs);
    send_byte(8'(len), hs);
    if (len <= DEPTH) begin
      for (int i = 0; i < len; i++) begin
        send_byte(words[i][15:8], hs);
        send_byte(words[i][7:0], hs);
        if (hs >= 0) expq.push_back('{due: hs + 1, addr: AW'(i), data: words[i]});
      end
      if (CHK_EN) send_byte(bad_chk ? (xor_of(len) ^ 8'h01) : xor_of(len), hs);
    end
    repeat (4) drive_idle();
    chk("queue_drained", expq.size(), 0);
    chk("frame_done", done_o, ok);
    chk("frame_error", error_o, !ok);
    chk("frame_core_rst", core_rst_o, ok);
    chk("frame_ready", byte_ready_o, ok);
    if (!ok) begin
      @(negedge clk); clear_i = 1'b1;
      @(negedge clk); clear_i = 1'b0;
      chk("clear_error", {error_o, byte_ready_o, core_rst_o}, 3'b010);
    end
  endtask

  initial begin
    int hs;
    // Reset behaviour with core held.
    @(posedge clk);
    mon_en = 1'b1;
    repeat (9) begin
      @(negedge clk);
      chk("reset_outputs", {byte_ready_o, mem_we_o, core_rst_o, done_o, error_o, mem_addr_o, mem_wdata_o}, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_ready_core", {byte_ready_o, core_rst_o}, 2'b10);

    // Two-word frame, then the same with a 1-of-3 valid pattern.
    words = {16'h1234, 16'hABCD};
    chk("model_xor_2word", xor_of(2), 8'h42);
    run_frame(2, 0, 1'b0);
    chk("mem0_1234", obs_mem[0], 16'h1234);
    chk("mem1_abcd", obs_mem[1], 16'hABCD);
    stall = 1'b1;
    run_frame(2, 0, 1'b0);
    stall = 1'b0;

    // Garbage before sync, single word.
    words = {16'hBEEF};
    chk("model_xor_beef", xor_of(1), 8'h50);
    send_byte(8'h00, hs); send_byte(8'hFF, hs); send_byte(8'h5A, hs);
    run_frame(1, 0, 1'b0);
    chk("mem0_beef", obs_mem[0], 16'hBEEF);

    // Length boundaries: full depth, one past, zero, huge.
    rand_words(DEPTH);
    run_frame(DEPTH, 0, 1'b0);
    run_frame(DEPTH + 1, 0, 1'b0);
    words = {};
    run_frame(0, 0, 1'b0);
    run_frame(16'hFFFF, 1, 1'b0);

    // Bad check byte (only meaningful with the checksum build).
    words = {16'h1234, 16'hABCD};
    run_frame(2, 0, 1'b1);

    // Reset mid-frame: written word stays, nothing after it.
    rand_words(3);
    send_byte(8'hA5, hs);
    sync_cyc = hs;
    send_byte(8'h00, hs);
    send_byte(8'h03, hs);
    send_byte(words[0][15:8], hs);
    send_byte(words[0][7:0], hs);
    expq.push_back('{due: hs + 1, addr: '0, data: words[0]});
    send_byte(words[1][15:8], hs);
    repeat (3) drive_idle();
    rst = 1'b0;
    repeat (3) drive_idle();
    chk("midframe_rst_outputs", {byte_ready_o, core_rst_o, done_o, error_o, mem_we_o}, 0);
    chk("midframe_kept_word", obs_mem[0], words[0]);
    rst = 1'b1;
    drive_idle();
    chk("midframe_rst_idle_ready", {byte_ready_o, core_rst_o}, 2'b10);

    // Random frames.
    for (int f = 0; f < 12; f++) begin
      int len;
      len = (f % 5 == 4) ? int'($urandom_range(DEPTH + 1, 40)) : int'($urandom_range(0, DEPTH));
      rand_words(len <= DEPTH ? len : 0);
      stall = ($urandom_range(0, 1) == 1);
      run_frame(len, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end
    stall = 1'b0;
    repeat (3) drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required completion");
    $fatal(1);
  end
endmodule
